// File: rtl/ctrl_cmd_issuer_pkg.sv
// ============================================================================
// Module   : ctrl_cmd_pkg
// Brief    : Shared constants, command code type and action index names for
//            the control command issuer and its round-robin picker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_cmd_pkg;

  localparam int N_REQ   = 26;
  localparam int IDX_W   = 5;
  localparam int MOD_W   = 2;
  localparam int CODE_W  = MOD_W + IDX_W;
  localparam int MERGE_W = 8;

  typedef struct packed {
    logic [MOD_W-1:0] mod;
    logic [IDX_W-1:0] idx;
  } cmd_code_t;

  // Action numbering matches the decoder's output line numbering.
  typedef enum logic [IDX_W-1:0] {
    ACT_00 = 5'd0,  ACT_01 = 5'd1,  ACT_02 = 5'd2,  ACT_03 = 5'd3,
    ACT_04 = 5'd4,  ACT_05 = 5'd5,  ACT_06 = 5'd6,  ACT_07 = 5'd7,
    ACT_08 = 5'd8,  ACT_09 = 5'd9,  ACT_10 = 5'd10, ACT_11 = 5'd11,
    ACT_12 = 5'd12, ACT_13 = 5'd13, ACT_14 = 5'd14, ACT_15 = 5'd15,
    ACT_16 = 5'd16, ACT_17 = 5'd17, ACT_18 = 5'd18, ACT_19 = 5'd19,
    ACT_20 = 5'd20, ACT_21 = 5'd21, ACT_22 = 5'd22, ACT_23 = 5'd23,
    ACT_24 = 5'd24, ACT_25 = 5'd25
  } action_e;

endpackage

`default_nettype wire

// File: rtl/ctrl_cmd_issuer_if.sv
// ============================================================================
// Module   : ctrl_cmd_issuer_if
// Brief    : Request-side and command-side bus of the control command issuer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ctrl_cmd_issuer_if
  import ctrl_cmd_pkg::*;
();

  logic [N_REQ-1:0]   req_set;
  logic [MOD_W-1:0]   req_mod;
  logic               flush;
  logic               cmd_valid;
  logic               cmd_ready;
  cmd_code_t          cmd_code;
  logic [N_REQ-1:0]   pending;
  logic               busy;
  logic [MERGE_W-1:0] merge_cnt;

  modport master (
    output req_set, req_mod, flush, cmd_ready,
    input  cmd_valid, cmd_code, pending, busy, merge_cnt
  );

  modport slave (
    input  req_set, req_mod, flush, cmd_ready,
    output cmd_valid, cmd_code, pending, busy, merge_cnt
  );

endinterface

`default_nettype wire

// File: rtl/ctrl_cmd_issuer_rr_pick26.sv
// ============================================================================
// Module   : rr_pick26
// Brief    : Combinational round-robin find-first over N_REQ request bits,
//            searching upward from (ptr+1) mod N_REQ with wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick26
  import ctrl_cmd_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam logic [IDX_W:0] c_num_req = (IDX_W+1)'(N_REQ);

  logic [IDX_W:0]   w_sum  [N_REQ];
  logic [IDX_W-1:0] w_cand [N_REQ];

  // Candidate k is the (k+1)-th index after the pointer; ptr < N_REQ keeps one wrap enough.
  generate
    for (genvar k = 0; k < N_REQ; k++) begin : g_cand
      assign w_sum[k]  = {1'b0, ptr_i} + (IDX_W+1)'(k + 1);
      assign w_cand[k] = (w_sum[k] >= c_num_req) ? IDX_W'(w_sum[k] - c_num_req)
                                                 : w_sum[k][IDX_W-1:0];
    end
  endgenerate

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[w_cand[k]]) begin
        found_o = 1'b1;
        idx_o   = w_cand[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ctrl_cmd_issuer.sv
// ============================================================================
// Module   : ctrl_cmd_issuer
// Brief    : Collects sticky control-action requests and issues one 7-bit
//            command code per valid/ready handshake, round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_cmd_issuer
  import ctrl_cmd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  ctrl_cmd_issuer_if.slave bus
);

  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [MOD_W-1:0]   mod_q [N_REQ];
  logic [MOD_W-1:0]   mod_d [N_REQ];
  logic               cmd_valid_q, cmd_valid_d;
  cmd_code_t          cmd_code_q, cmd_code_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [MERGE_W-1:0] merge_q, merge_d;

  logic               w_found;
  logic [IDX_W-1:0]   w_sel;
  logic               w_load;
  logic [N_REQ-1:0]   w_clr;
  logic [N_REQ-1:0]   w_merge_hit;
  logic [IDX_W:0]     w_hits;
  logic [MERGE_W:0]   w_merge_sum;

  rr_pick26 u_pick (
    .req_i   (pending_q),
    .ptr_i   (rr_q),
    .found_o (w_found),
    .idx_o   (w_sel)
  );

  // A bit set in the same cycle it is issued re-arms as a fresh request, not a merge.
  always_comb begin
    w_load = (~cmd_valid_q | bus.cmd_ready) & w_found;
    w_clr  = '0;
    if (w_load) begin
      w_clr[w_sel] = 1'b1;
    end
    w_merge_hit = bus.req_set & pending_q & ~w_clr;
    w_hits      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_hits = w_hits + (IDX_W+1)'(w_merge_hit[i]);
    end
    w_merge_sum = {1'b0, merge_q} + (MERGE_W+1)'(w_hits);
  end

  always_comb begin
    pending_d   = pending_q;
    mod_d       = mod_q;
    cmd_valid_d = cmd_valid_q;
    cmd_code_d  = cmd_code_q;
    rr_d        = rr_q;
    merge_d     = merge_q;
    if (bus.flush) begin
      pending_d   = '0;
      cmd_valid_d = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        mod_d[i] = '0;
      end
    end else begin
      pending_d = (pending_q & ~w_clr) | bus.req_set;
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_set[i]) begin
          mod_d[i] = bus.req_mod;
        end
      end
      merge_d = w_merge_sum[MERGE_W] ? '1 : w_merge_sum[MERGE_W-1:0];
      if (w_load) begin
        cmd_code_d.mod = mod_q[w_sel];
        cmd_code_d.idx = w_sel;
        cmd_valid_d    = 1'b1;
        rr_d           = w_sel;
      end else if (bus.cmd_ready) begin
        cmd_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      rr_q        <= IDX_W'(N_REQ - 1);
      merge_q     <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        mod_q[i] <= '0;
      end
    end else begin
      pending_q   <= pending_d;
      mod_q       <= mod_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      rr_q        <= rr_d;
      merge_q     <= merge_d;
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_code  = cmd_code_q;
  assign bus.pending   = pending_q;
  assign bus.busy      = cmd_valid_q | (|pending_q);
  assign bus.merge_cnt = merge_q;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_cmd_issuer.sv
// ============================================================================
// Module   : tb_ctrl_cmd_issuer
// Brief    : Self-checking bench for ctrl_cmd_issuer with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_cmd_issuer;
  import ctrl_cmd_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ctrl_cmd_issuer_if u_if ();

  ctrl_cmd_issuer u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: sticky request set, round-robin issue, one output slot.
  bit [25:0] m_pend;
  bit [1:0]  m_mod [26];
  bit        m_valid;
  bit [6:0]  m_code;
  int        m_rr;
  int        m_merge;

  task automatic model_reset();
    m_pend = '0;
    foreach (m_mod[i]) m_mod[i] = 2'b00;
    m_valid = 1'b0;
    m_code  = '0;
    m_rr    = 25;
    m_merge = 0;
  endtask

  task automatic model_step(input logic [25:0] set, input logic [1:0] md,
                            input logic fl, input logic rdy);
    bit ld;
    int sel;
    if (fl) begin
      m_pend = '0;
      foreach (m_mod[i]) m_mod[i] = 2'b00;
      m_valid = 1'b0;
      return;
    end
    ld  = (!m_valid || rdy) && (m_pend != 0);
    sel = -1;
    if (ld) begin
      for (int k = 1; k <= 26; k++) begin
        int j;
        j = (m_rr + k) % 26;
        if (m_pend[j] && sel < 0) sel = j;
      end
    end
    for (int i = 0; i < 26; i++) begin
      if (set[i] && m_pend[i] && !(ld && i == sel))
        m_merge = (m_merge < 255) ? m_merge + 1 : 255;
    end
    if (ld) begin
      m_code     = {m_mod[sel], 5'(sel)};
      m_valid    = 1'b1;
      m_rr       = sel;
      m_pend[sel] = 1'b0;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < 26; i++) begin
      if (set[i]) begin
        m_pend[i] = 1'b1;
        m_mod[i]  = md;
      end
    end
  endtask

  task automatic step(input logic [25:0] set, input logic [1:0] md,
                      input logic fl, input logic rdy);
    u_if.req_set   = set;
    u_if.req_mod   = md;
    u_if.flush     = fl;
    u_if.cmd_ready = rdy;
    @(posedge clk);
    model_step(set, md, fl, rdy);
    #1;
  endtask

  task automatic apply_reset();
    u_if.req_set   = '0;
    u_if.req_mod   = '0;
    u_if.flush     = 1'b0;
    u_if.cmd_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    u_if.req_set   = '0;
    u_if.req_mod   = '0;
    u_if.flush     = 1'b0;
    u_if.cmd_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (u_if.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", u_if.cmd_valid); end
    checks++; if (u_if.cmd_code !== 7'd0) begin errors++; $display("FAIL reset_code got %h want 00", u_if.cmd_code); end
    checks++; if (u_if.pending !== 26'd0) begin errors++; $display("FAIL reset_pending got %h want 0", u_if.pending); end
    checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", u_if.busy); end
    checks++; if (u_if.merge_cnt !== 8'd0) begin errors++; $display("FAIL reset_merge got %0d want 0", u_if.merge_cnt); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    apply_reset();
    step(26'd1 << 3, 2'b10, 1'b0, 1'b1);
    checks++; if (u_if.cmd_valid !== 1'b0 || u_if.pending !== 26'h8) begin
      errors++; $display("FAIL single_latency got v=%b p=%h want v=0 p=0000008", u_if.cmd_valid, u_if.pending); end
    step('0, 2'b00, 1'b0, 1'b1);
    checks++; if (u_if.cmd_valid !== 1'b1 || u_if.cmd_code !== 7'b10_00011) begin
      errors++; $display("FAIL single_code got v=%b c=%b want v=1 c=1000011", u_if.cmd_valid, u_if.cmd_code); end
    checks++; if (u_if.cmd_code !== m_code) begin errors++; $display("FAIL single_model got %h want %h", u_if.cmd_code, m_code); end
    step('0, 2'b00, 1'b0, 1'b1);
    checks++; if (u_if.busy !== 1'b0 || u_if.pending !== 26'd0 || u_if.cmd_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle got b=%b p=%h v=%b want 0 0 0", u_if.busy, u_if.pending, u_if.cmd_valid); end
  endtask

  task automatic test_sweep();
    apply_reset();
    step({26{1'b1}}, 2'b01, 1'b0, 1'b1);
    for (int k = 0; k < 26; k++) begin
      logic [6:0] want;
      step('0, 2'b00, 1'b0, 1'b1);
      want = {2'b01, 5'(k)};
      checks++; if (u_if.cmd_valid !== 1'b1 || u_if.cmd_code !== want || u_if.cmd_code !== m_code) begin
        errors++; $display("FAIL sweep_code[%0d] got v=%b c=%h want v=1 c=%h", k, u_if.cmd_valid, u_if.cmd_code, want); end
    end
    step('0, 2'b00, 1'b0, 1'b1);
    checks++; if (u_if.cmd_valid !== 1'b0 || u_if.busy !== 1'b0) begin
      errors++; $display("FAIL sweep_end got v=%b b=%b want 0 0", u_if.cmd_valid, u_if.busy); end
  endtask

  task automatic test_stall();
    int issues;
    apply_reset();
    step(26'd1 << 7, 2'b11, 1'b0, 1'b0);
    step('0, 2'b00, 1'b0, 1'b0);
    issues = 0;
    for (int k = 0; k < 5; k++) begin
      step('0, 2'b00, 1'b0, 1'b0);
      checks++; if (u_if.cmd_valid !== 1'b1 || u_if.cmd_code !== 7'b11_00111) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b c=%b want v=1 c=1100111", k, u_if.cmd_valid, u_if.cmd_code); end
    end
    for (int k = 0; k < 3; k++) begin
      if (u_if.cmd_valid === 1'b1) issues++;
      step('0, 2'b00, 1'b0, 1'b1);
    end
    checks++; if (issues !== 1 || u_if.cmd_valid !== 1'b0 || u_if.pending !== 26'd0) begin
      errors++; $display("FAIL stall_accept got issues=%0d v=%b want issues=1 v=0", issues, u_if.cmd_valid); end
  endtask

  task automatic test_merge();
    int fives;
    apply_reset();
    step(26'd1, 2'b00, 1'b0, 1'b0);
    step(26'd1 << 5, 2'b01, 1'b0, 1'b0);
    step(26'd1 << 5, 2'b11, 1'b0, 1'b0);
    checks++; if (u_if.merge_cnt !== 8'd1 || u_if.merge_cnt !== 8'(m_merge)) begin
      errors++; $display("FAIL merge_cnt got %0d want 1", u_if.merge_cnt); end
    fives = 0;
    for (int k = 0; k < 4; k++) begin
      step('0, 2'b00, 1'b0, 1'b1);
      if (u_if.cmd_valid === 1'b1 && u_if.cmd_code.idx === 5'd5) begin
        fives++;
        checks++; if (u_if.cmd_code.mod !== 2'b11) begin
          errors++; $display("FAIL merge_mod got %b want 11", u_if.cmd_code.mod); end
      end
    end
    checks++; if (fives !== 1) begin errors++; $display("FAIL merge_issue_count got %0d want 1", fives); end
  endtask

  task automatic test_set_on_load();
    apply_reset();
    step(26'd1 << 9, 2'b01, 1'b0, 1'b1);
    step(26'd1 << 9, 2'b10, 1'b0, 1'b1);
    checks++; if (u_if.cmd_code !== 7'b01_01001 || u_if.pending !== (26'd1 << 9) || u_if.merge_cnt !== 8'd0) begin
      errors++; $display("FAIL setload_first got c=%b p=%h m=%0d want c=0101001 p=0000200 m=0", u_if.cmd_code, u_if.pending, u_if.merge_cnt); end
    step('0, 2'b00, 1'b0, 1'b1);
    checks++; if (u_if.cmd_valid !== 1'b1 || u_if.cmd_code !== 7'b10_01001 || u_if.pending !== 26'd0) begin
      errors++; $display("FAIL setload_second got v=%b c=%b p=%h want v=1 c=1001001 p=0", u_if.cmd_valid, u_if.cmd_code, u_if.pending); end
  endtask

  task automatic test_flush();
    logic [7:0] mc;
    apply_reset();
    step((26'd1 << 2) | (26'd1 << 20), 2'b01, 1'b0, 1'b0);
    step('0, 2'b00, 1'b0, 1'b0);
    mc = u_if.merge_cnt;
    checks++; if (u_if.cmd_valid !== 1'b1 || u_if.cmd_code.idx !== 5'd2) begin
      errors++; $display("FAIL flush_pre got v=%b idx=%0d want v=1 idx=2", u_if.cmd_valid, u_if.cmd_code.idx); end
    step(26'd1 << 7, 2'b11, 1'b1, 1'b0);
    checks++; if (u_if.cmd_valid !== 1'b0 || u_if.pending !== 26'd0 || u_if.busy !== 1'b0 || u_if.merge_cnt !== mc) begin
      errors++; $display("FAIL flush_clear got v=%b p=%h b=%b m=%0d want 0 0 0 %0d", u_if.cmd_valid, u_if.pending, u_if.busy, u_if.merge_cnt, mc); end
    step((26'd1 << 1) | (26'd1 << 3), 2'b00, 1'b0, 1'b1);
    step('0, 2'b00, 1'b0, 1'b1);
    checks++; if (u_if.cmd_code.idx !== 5'd3 || u_if.cmd_code !== m_code) begin
      errors++; $display("FAIL flush_rr got idx=%0d want 3", u_if.cmd_code.idx); end
  endtask

  task automatic test_saturate();
    apply_reset();
    step(26'd1, 2'b00, 1'b0, 1'b0);
    step({26{1'b1}}, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step({26{1'b1}}, 2'b10, 1'b0, 1'b0);
    checks++; if (u_if.merge_cnt !== 8'd255 || u_if.merge_cnt !== 8'(m_merge)) begin
      errors++; $display("FAIL saturate got %0d want 255", u_if.merge_cnt); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step({26{1'b1}}, 2'b01, 1'b0, 1'b1);
    repeat (3) step(26'h2A5A5A5, 2'b10, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (u_if.cmd_valid !== 1'b0 || u_if.pending !== 26'd0 || u_if.busy !== 1'b0 ||
                  u_if.merge_cnt !== 8'd0 || u_if.cmd_code !== 7'd0) begin
      errors++; $display("FAIL async_reset got v=%b p=%h b=%b m=%0d c=%h want all 0", u_if.cmd_valid, u_if.pending, u_if.busy, u_if.merge_cnt, u_if.cmd_code); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    int bad;
    apply_reset();
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      logic [25:0] set;
      set = 26'($urandom) & 26'($urandom) & 26'($urandom);
      step(set, 2'($urandom_range(0, 3)), ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0));
      checks++;
      if (u_if.cmd_valid !== m_valid || (m_valid && u_if.cmd_code !== m_code) || u_if.pending !== m_pend ||
          u_if.busy !== (m_valid | (m_pend != 0)) || u_if.merge_cnt !== 8'(m_merge)) begin
        errors++;
        if (bad < 10) $display("FAIL random[%0d] got v=%b c=%h p=%h m=%0d want v=%b c=%h p=%h m=%0d",
                               n, u_if.cmd_valid, u_if.cmd_code, u_if.pending, u_if.merge_cnt, m_valid, m_code, m_pend, m_merge);
        bad++;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_sweep();
    test_stall();
    test_merge();
    test_set_on_load();
    test_flush();
    test_saturate();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
